// File: rtl/weapon_attack.sv
// Player sword-attack controller: WINDUP/ACTIVE/COOLDOWN sequencing, hitbox placement
// in front of the player, and overlap detection against one monster.
module weapon_attack #(
  parameter int WINDUP_CYC   = 4,
  parameter int ACTIVE_CYC   = 16,
  parameter int COOLDOWN_CYC = 24,
  parameter int REACH        = 16,
  parameter int HIT_SIZE     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] stage,
  input  logic       attack_btn,
  input  logic [9:0] player_pos_h,
  input  logic [9:0] player_pos_v,
  input  logic [1:0] player_dir,
  input  logic [9:0] monster_pos_h,
  input  logic [9:0] monster_pos_v,
  output logic       enable_weapon_collision,
  output logic       weapon_collision,
  output logic [3:0] weapon_state,
  output logic [9:0] weapon_pos_h,
  output logic [9:0] weapon_pos_v,
  output logic [7:0] hit_count
);

  typedef enum logic [3:0] {
    IDLE     = 4'hf,
    WINDUP   = 4'h0,
    ACTIVE   = 4'h1,
    COOLDOWN = 4'h2
  } state_t;

  localparam logic [10:0] REACH_W = 11'(REACH);
  localparam logic [10:0] HIT_W   = 11'(HIT_SIZE);

  state_t     state;
  logic       btn_d;
  logic [7:0] cnt;
  logic [1:0] dir_l;
  logic       overlap_r;
  logic       hit_flag;

  logic       playing;
  logic       press;
  logic       phase_done;
  logic [9:0] box_h;
  logic [9:0] box_v;

  function automatic logic [9:0] sat_add(input logic [9:0] p);
    logic [10:0] s;
    s = {1'b0, p} + REACH_W;
    return s[10] ? 10'h3ff : s[9:0];
  endfunction

  // A borrow out of the 11-bit difference means the result went negative.
  function automatic logic [9:0] sat_sub(input logic [9:0] p);
    logic [10:0] s;
    s = {1'b0, p} - REACH_W;
    return s[10] ? 10'h000 : s[9:0];
  endfunction

  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return $unsigned(d) < HIT_W;
  endfunction

  assign playing          = (stage != 4'h0) && (stage != 4'hf);
  assign press            = attack_btn & ~btn_d;
  assign weapon_state     = state;
  assign weapon_collision = overlap_r & (state == ACTIVE);

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    phase_done = 1'b0;
    box_h      = player_pos_h;
    box_v      = player_pos_v;
    case (state)
      WINDUP:   phase_done = (cnt == 8'(WINDUP_CYC - 1));
      ACTIVE:   phase_done = (cnt == 8'(ACTIVE_CYC - 1));
      COOLDOWN: phase_done = (cnt == 8'(COOLDOWN_CYC - 1));
      default:  phase_done = 1'b0;
    endcase
    case (dir_l)
      2'd0:    box_h = sat_add(player_pos_h);
      2'd1:    box_h = sat_sub(player_pos_h);
      2'd2:    box_v = sat_add(player_pos_v);
      default: box_v = sat_sub(player_pos_v);
    endcase
  end

  // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      btn_d                   <= 1'b0;
      cnt                     <= '0;
      dir_l                   <= '0;
      overlap_r               <= 1'b0;
      hit_flag                <= 1'b0;
      enable_weapon_collision <= 1'b0;
      weapon_pos_h            <= '0;
      weapon_pos_v            <= '0;
      hit_count               <= '0;
    end else if (!playing) begin
      // Leaving the playfield behaves like reset and beats any pending press.
      state                   <= IDLE;
      btn_d                   <= 1'b0;
      cnt                     <= '0;
      dir_l                   <= '0;
      overlap_r               <= 1'b0;
      hit_flag                <= 1'b0;
      enable_weapon_collision <= 1'b0;
      weapon_pos_h            <= '0;
      weapon_pos_v            <= '0;
      hit_count               <= '0;
    end else begin
      btn_d     <= attack_btn;
      overlap_r <= near(weapon_pos_h, monster_pos_h) & near(weapon_pos_v, monster_pos_v);

      case (state)
        IDLE: begin
          if (press) begin
            state    <= WINDUP;
            cnt      <= '0;
            dir_l    <= player_dir;
            hit_flag <= 1'b0;
          end
        end
        WINDUP: begin
          if (phase_done) begin
            state                   <= ACTIVE;
            cnt                     <= '0;
            weapon_pos_h            <= box_h;
            weapon_pos_v            <= box_v;
            // Overlap from the previous hitbox position must not leak into this attack.
            overlap_r               <= 1'b0;
            enable_weapon_collision <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACTIVE: begin
          if (phase_done) begin
            state                   <= COOLDOWN;
            cnt                     <= '0;
            enable_weapon_collision <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        COOLDOWN: begin
          if (phase_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (weapon_collision && !hit_flag) begin
        hit_flag <= 1'b1;
        if (hit_count != 8'hff) hit_count <= hit_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_weapon_attack.sv
// Randomized bench for weapon_attack: stimulus pushes the expected attack outcome into a
// scoreboard, and a negedge monitor checks each ACTIVE window as the DUT produces it.
module tb_weapon_attack;

  localparam int W     = 4;
  localparam int A     = 16;
  localparam int C     = 24;
  localparam int REACH = 16;
  localparam int HS    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] stage;
  logic       attack_btn;
  logic [9:0] player_pos_h, player_pos_v;
  logic [1:0] player_dir;
  logic [9:0] monster_pos_h, monster_pos_v;
  logic       enable_weapon_collision, weapon_collision;
  logic [3:0] weapon_state;
  logic [9:0] weapon_pos_h, weapon_pos_v;
  logic [7:0] hit_count;

  weapon_attack #(
    .WINDUP_CYC(W), .ACTIVE_CYC(A), .COOLDOWN_CYC(C), .REACH(REACH), .HIT_SIZE(HS)
  ) dut (
    .clk(clk), .rst(rst), .stage(stage), .attack_btn(attack_btn),
    .player_pos_h(player_pos_h), .player_pos_v(player_pos_v), .player_dir(player_dir),
    .monster_pos_h(monster_pos_h), .monster_pos_v(monster_pos_v),
    .enable_weapon_collision(enable_weapon_collision), .weapon_collision(weapon_collision),
    .weapon_state(weapon_state), .weapon_pos_h(weapon_pos_h), .weapon_pos_v(weapon_pos_v),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int start;
    int wh;
    int wv;
    int coll;
    int hc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   hc_model = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int sat(input int x);
    return (x < 0) ? 0 : ((x > 1023) ? 1023 : x);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Monitor: one ACTIVE window per expected attack, then the return to IDLE.
  bit in_act = 1'b0, wait_idle = 1'b0;
  int act_len = 0, coll_cnt = 0;
  always @(negedge clk) begin
    if (!mon_en) begin
      in_act    = 1'b0;
      wait_idle = 1'b0;
    end else begin
      if (!in_act && enable_weapon_collision) begin
        in_act   = 1'b1;
        act_len  = 1;
        coll_cnt = int'(weapon_collision);
        check("first_active_no_collision", int'(weapon_collision), 0);
        if (sb.size() == 0) begin
          check("unexpected_attack", 1, 0);
          cur = '{start: cyc, wh: 0, wv: 0, coll: 0, hc: hc_model};
        end else begin
          cur = sb.pop_front();
          check("active_start_cycle", cyc, cur.start);
          check("weapon_pos_h", int'(weapon_pos_h), cur.wh);
          check("weapon_pos_v", int'(weapon_pos_v), cur.wv);
        end
      end else if (in_act && enable_weapon_collision) begin
        act_len++;
        coll_cnt += int'(weapon_collision);
        check("state_active_while_enabled", int'(weapon_state), 1);
      end else if (in_act && !enable_weapon_collision) begin
        in_act    = 1'b0;
        wait_idle = 1'b1;
        check("active_length", act_len, A);
        check("collision_cycles", coll_cnt, cur.coll);
        check("cooldown_state", int'(weapon_state), 2);
      end
      if (wait_idle && weapon_state == 4'hf) begin
        wait_idle = 1'b0;
        check("idle_return_cycle", cyc, cur.start + A + C);
        check("hit_count", int'(hit_count), cur.hc);
      end
    end
  end

  task automatic do_attack(input int ph, input int pv, input int dir,
                           input int mh, input int mv, input int hold);
    int   e, wh, wv;
    bit   hit;
    exp_t x;
    @(negedge clk);
    player_pos_h  = 10'(ph);
    player_pos_v  = 10'(pv);
    player_dir    = 2'(dir);
    monster_pos_h = 10'(mh);
    monster_pos_v = 10'(mv);
    wh = sat(ph + ((dir == 0) ? REACH : (dir == 1) ? -REACH : 0));
    wv = sat(pv + ((dir == 2) ? REACH : (dir == 3) ? -REACH : 0));
    hit = (iabs(wh - mh) < HS) && (iabs(wv - mv) < HS);
    if (hit && hc_model < 255) hc_model++;
    e = cyc + 1;
    x = '{start: e + W, wh: wh, wv: wv, coll: hit ? A - 1 : 0, hc: hc_model};
    sb.push_back(x);
    attack_btn = 1'b1;
    repeat (hold) @(negedge clk);
    attack_btn = 1'b0;
    if (hold < 25) begin
      while (cyc < e + W + A + 6) @(negedge clk);
      attack_btn = 1'b1;
      @(negedge clk);
      attack_btn = 1'b0;
    end
    while (cyc < e + W + A + C + 2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int ph, pv, dir, wh, wv, e;
    rst           = 1'b1;
    stage         = 4'h0;
    attack_btn    = 1'b0;
    player_pos_h  = '0;
    player_pos_v  = '0;
    player_dir    = '0;
    monster_pos_h = '0;
    monster_pos_v = '0;
    #2;
    check("reset_weapon_state", int'(weapon_state), 15);
    check("reset_enable", int'(enable_weapon_collision), 0);
    check("reset_collision", int'(weapon_collision), 0);
    check("reset_pos_h", int'(weapon_pos_h), 0);
    check("reset_pos_v", int'(weapon_pos_v), 0);
    check("reset_hit_count", int'(hit_count), 0);

    @(negedge clk);
    rst   = 1'b0;
    stage = 4'h1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    do_attack(100, 100, 0, 116, 100, 3);     // touching hitbox: hit
    do_attack(100, 100, 0, 132, 100, 100);   // |dh| = 16: miss, button held long
    do_attack(100, 100, 0, 131, 115, 2);     // corner just inside: hit, re-press in cooldown
    do_attack(5, 50, 1, 0, 50, 1);           // left edge saturates to 0
    do_attack(1015, 50, 0, 1023, 50, 4);     // right edge saturates to 1023
    do_attack(300, 1020, 2, 300, 1023, 2);
    do_attack(300, 3, 3, 310, 20, 30);

    for (int i = 0; i < 10; i++) begin
      ph  = int'($urandom_range(0, 1023));
      pv  = int'($urandom_range(0, 1023));
      dir = int'($urandom_range(0, 3));
      wh  = sat(ph + ((dir == 0) ? REACH : (dir == 1) ? -REACH : 0));
      wv  = sat(pv + ((dir == 2) ? REACH : (dir == 3) ? -REACH : 0));
      stage = 4'($urandom_range(1, 14));
      do_attack(ph, pv, dir, sat(wh + int'($urandom_range(0, 40)) - 20),
                sat(wv + int'($urandom_range(0, 40)) - 20), int'($urandom_range(1, 60)));
    end

    // Stage drops out in the middle of ACTIVE.
    mon_en = 1'b0;
    stage  = 4'h1;
    @(negedge clk);
    player_pos_h  = 10'd100;
    player_pos_v  = 10'd100;
    player_dir    = 2'd0;
    monster_pos_h = 10'd116;
    monster_pos_v = 10'd100;
    attack_btn    = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    attack_btn = 1'b0;
    while (cyc < e + W + 7) @(negedge clk);
    check("abort_enable_before", int'(enable_weapon_collision), 1);
    check("abort_collision_before", int'(weapon_collision), 1);
    stage = 4'h0;
    @(negedge clk);
    check("abort_weapon_state", int'(weapon_state), 15);
    check("abort_enable", int'(enable_weapon_collision), 0);
    check("abort_collision", int'(weapon_collision), 0);
    check("abort_hit_count", int'(hit_count), 0);
    hc_model = 0;
    stage    = 4'h3;
    repeat (2) @(negedge clk);

    // Asynchronous reset during WINDUP, observed before the next edge.
    attack_btn = 1'b1;
    @(negedge clk);
    attack_btn = 1'b0;
    check("windup_before_rst", int'(weapon_state), 0);
    #1 rst = 1'b1;
    #1;
    check("rst_weapon_state", int'(weapon_state), 15);
    check("rst_enable", int'(enable_weapon_collision), 0);
    check("rst_collision", int'(weapon_collision), 0);
    check("rst_pos_h", int'(weapon_pos_h), 0);
    check("rst_pos_v", int'(weapon_pos_v), 0);
    check("rst_hit_count", int'(hit_count), 0);
    @(negedge clk);
    rst      = 1'b0;
    hc_model = 0;
    @(negedge clk);
    mon_en = 1'b1;
    do_attack(200, 200, 2, 205, 220, 3);
    do_attack(200, 200, 3, 190, 180, 3);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("monitor_settled", int'(in_act) + int'(wait_idle), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
